// File: rtl/dmem_if.sv
// Load/store request/response bus between the CPU memory stage (master)
// and a data-memory responder (slave).
interface dmem_if #(
   parameter int WIDTH = 32
);
   logic             req_valid;
   logic             req_ready;
   logic             req_write;
   logic [WIDTH-1:0] req_addr;
   logic [2:0]       req_funct3;
   logic [WIDTH-1:0] req_wdata;
   logic             resp_valid;
   logic             resp_ready;
   logic [WIDTH-1:0] resp_rdata;
   logic             resp_err;

   modport master (
      output req_valid, req_write, req_addr, req_funct3, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_funct3, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle RV32 data-memory responder: one outstanding request, fixed LATENCY.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word accesses as errors.
module dmem_responder #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 12,
   parameter int LATENCY    = 2
) (
   input logic   clk,
   input logic   rst,
   dmem_if.slave bus
);
   localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
   localparam int NB    = WIDTH / 8;
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  wr_q, wr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [2:0]            f3_q, f3_d;
   logic [WIDTH-1:0]      wdata_q, wdata_d;
   logic                  resp_valid_q, resp_valid_d;
   logic [WIDTH-1:0]      rdata_q, rdata_d;
   logic                  err_q, err_d;

   // NOTE: the array has no reset; clearing it would force a flop-based
   // implementation and software never relies on its power-up contents.
   logic [WIDTH-1:0] mem [DEPTH];

   logic                  accept;
   logic                  enter_resp;
   logic                  op_write;
   logic [ADDR_WIDTH-1:0] op_addr;
   logic [2:0]            op_f3;
   logic [WIDTH-1:0]      op_wdata;
   logic                  op_err;
   logic [WIDTH-1:0]      rd_word;
   logic [7:0]            lane_byte;
   logic [15:0]           lane_half;
   logic [WIDTH-1:0]      load_val;
   logic [NB-1:0]         wr_be;
   logic [WIDTH-1:0]      wr_data;
   logic                  mem_we;
   logic                  unused_addr_hi;

   assign unused_addr_hi = ^bus.req_addr[WIDTH-1:ADDR_WIDTH];

   assign bus.req_ready  = (state_q == S_IDLE) && !rst;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;

   assign accept = bus.req_valid && bus.req_ready;

   // With LATENCY==1 RESP is entered on the accept edge, so decode the live request.
   assign op_write = accept ? bus.req_write                   : wr_q;
   assign op_addr  = accept ? bus.req_addr[ADDR_WIDTH-1:0]    : addr_q;
   assign op_f3    = accept ? bus.req_funct3                  : f3_q;
   assign op_wdata = accept ? bus.req_wdata                   : wdata_q;

   assign rd_word   = mem[op_addr[ADDR_WIDTH-1:2]];
   assign lane_byte = rd_word[{op_addr[1:0], 3'b000} +: 8];
   assign lane_half = rd_word[{op_addr[1], 4'b0000} +: 16];

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      logic legal;
      logic misalign;
      legal    = 1'b0;
      misalign = 1'b0;
      load_val = '0;
      wr_be    = '0;
      wr_data  = op_wdata;
      if (op_write) begin
         case (op_f3)
            3'b000: begin
               legal   = 1'b1;
               wr_be   = NB'(1) << op_addr[1:0];
               wr_data = {NB{op_wdata[7:0]}};
            end
            3'b001: begin
               legal   = 1'b1;
               wr_be   = NB'(3) << {op_addr[1], 1'b0};
               wr_data = {(NB/2){op_wdata[15:0]}};
            end
            3'b010: begin
               legal = 1'b1;
               wr_be = '1;
            end
            default: legal = 1'b0;
         endcase
      end else begin
         case (op_f3)
            3'b000:  begin legal = 1'b1; load_val = {{(WIDTH-8){lane_byte[7]}}, lane_byte}; end
            3'b001:  begin legal = 1'b1; load_val = {{(WIDTH-16){lane_half[15]}}, lane_half}; end
            3'b010:  begin legal = 1'b1; load_val = rd_word; end
            3'b100:  begin legal = 1'b1; load_val = {{(WIDTH-8){1'b0}}, lane_byte}; end
            3'b101:  begin legal = 1'b1; load_val = {{(WIDTH-16){1'b0}}, lane_half}; end
            default: legal = 1'b0;
         endcase
      end
`ifdef DMEM_MISALIGN_TRAP_EN
      misalign = ((op_f3[1:0] == 2'b01) && op_addr[0]) ||
                 ((op_f3[1:0] == 2'b10) && (op_addr[1:0] != 2'b00));
`endif
      op_err = !legal || misalign;
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      wr_d         = wr_q;
      addr_d       = addr_q;
      f3_d         = f3_q;
      wdata_d      = wdata_q;
      resp_valid_d = resp_valid_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      enter_resp   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               wr_d    = bus.req_write;
               addr_d  = bus.req_addr[ADDR_WIDTH-1:0];
               f3_d    = bus.req_funct3;
               wdata_d = bus.req_wdata;
               cnt_d   = CNT_W'(LATENCY - 1);
               if (LATENCY == 1) begin
                  state_d    = S_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            // Counter is loaded with LATENCY-1 and RESP follows the edge after it hits 0.
            if (cnt_q == '0) begin
               state_d    = S_RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_RESP: begin
            if (bus.resp_ready) begin
               state_d      = S_IDLE;
               resp_valid_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (enter_resp) begin
         resp_valid_d = 1'b1;
         err_d        = op_err;
         rdata_d      = (op_err || op_write) ? '0 : load_val;
      end
   end

   assign mem_we = enter_resp && op_write && !op_err && !rst;

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         wr_q         <= 1'b0;
         addr_q       <= '0;
         f3_q         <= '0;
         wdata_q      <= '0;
         resp_valid_q <= 1'b0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         wr_q         <= wr_d;
         addr_q       <= addr_d;
         f3_q         <= f3_d;
         wdata_q      <= wdata_d;
         resp_valid_q <= resp_valid_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) mem[op_addr[ADDR_WIDTH-1:2]][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: byte-addressed reference model,
// per-cycle response compare, and literal expectations for the directed vectors.
module tb_dmem_responder;
   localparam int LAT = 2;

   typedef struct {
      logic [31:0] rd;
      logic        er;
      int          acc;
      logic        st;
      int          ea;
      int          n;
      logic [31:0] wd;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   logic [7:0] mmem [0:4095];
   exp_t       q[$];

   dmem_if #(.WIDTH(32)) bus ();

   dmem_responder #(.WIDTH(32), .ADDR_WIDTH(12), .LATENCY(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic w, input logic [31:0] addr,
                                  input logic [2:0] f3, input logic [31:0] wd);
      exp_t        e;
      int          a;
      int          n;
      logic        legal;
      logic        mis;
      logic [31:0] v;
      a     = int'(addr[11:0]);
      n     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      legal = w ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
      mis   = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      mis = (a % n) != 0;
`endif
      a    = a - (a % n);
      e.er = !legal || mis;
      e.rd = '0;
      e.st = w && !e.er;
      e.ea = a;
      e.n  = n;
      e.wd = wd;
      e.acc = 0;
      if (!w && !e.er) begin
         v = '0;
         for (int i = 0; i < n; i++) v[8*i +: 8] = mmem[a + i];
         if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
         e.rd = v;
      end
      return e;
   endfunction

   // Per-cycle compare against the model queue.
   logic        first = 1'b1;
   logic        hs_prev = 1'b0;
   logic [31:0] snap_rd;
   logic        snap_er;

   always @(negedge clk) begin
      if (rst) begin
         check("req_ready_in_reset", {31'b0, bus.req_ready}, 32'd0);
         first   = 1'b1;
         hs_prev = 1'b0;
      end else begin
         if (hs_prev) begin
            check("resp_valid_after_hs", {31'b0, bus.resp_valid}, 32'd0);
            check("req_ready_after_hs", {31'b0, bus.req_ready}, 32'd1);
         end
         hs_prev = 1'b0;
         if (bus.resp_valid) begin
            if (q.size() == 0) begin
               check("unexpected_resp", 32'd1, 32'd0);
            end else begin
               if (first) begin
                  check("latency", 32'(cyc - q[0].acc), 32'(LAT));
                  if (q[0].st)
                     for (int i = 0; i < q[0].n; i++) mmem[q[0].ea + i] = q[0].wd[8*i +: 8];
                  snap_rd = bus.resp_rdata;
                  snap_er = bus.resp_err;
                  first   = 1'b0;
               end else begin
                  check("rdata_stable", bus.resp_rdata, snap_rd);
                  check("err_stable", {31'b0, bus.resp_err}, {31'b0, snap_er});
               end
               check("rdata", bus.resp_rdata, q[0].rd);
               check("err", {31'b0, bus.resp_err}, {31'b0, q[0].er});
               check("req_ready_busy", {31'b0, bus.req_ready}, 32'd0);
               if (bus.resp_ready) begin
                  void'(q.pop_front());
                  first   = 1'b1;
                  hs_prev = 1'b1;
               end
            end
         end
      end
   end

   // Entered and left at posedge+1; returns the DUT response seen at handshake.
   task automatic issue(input logic w, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic er);
      exp_t e;
      int   t;
      rd = 'x;
      er = 1'bx;
      bus.req_valid  = 1'b1;
      bus.req_write  = w;
      bus.req_addr   = addr;
      bus.req_funct3 = f3;
      bus.req_wdata  = wd;
      t = 0;
      while (!bus.req_ready && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      if (!bus.req_ready) begin
         check("accept_timeout", 32'd1, 32'd0);
         bus.req_valid = 1'b0;
         return;
      end
      e     = model(w, addr, f3, wd);
      e.acc = cyc + 1;
      q.push_back(e);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      t = 0;
      while (!bus.resp_valid && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      if (!bus.resp_valid) begin
         check("resp_timeout", 32'd1, 32'd0);
         q.delete();
         return;
      end
      repeat (hold) begin
         @(posedge clk); #1;
      end
      rd = bus.resp_rdata;
      er = bus.resp_err;
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.resp_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_addr   = '0;
      bus.req_funct3 = '0;
      bus.req_wdata  = '0;
      bus.resp_ready = 1'b0;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_req_ready", {31'b0, bus.req_ready}, 32'd1);
      check("reset_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
      check("reset_rdata", bus.resp_rdata, 32'd0);
      check("reset_err", {31'b0, bus.resp_err}, 32'd0);
      @(posedge clk); #1;

      issue(1'b1, 32'h20, 3'b010, 32'h0, 0, rd, er);
      check("sw0_err", {31'b0, er}, 32'd0);

      issue(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 0, rd, er);
      issue(1'b0, 32'h10, 3'b010, 32'h0, 0, rd, er);
      check("t1_lw", rd, 32'hDEADBEEF);
      check("t1_err", {31'b0, er}, 32'd0);

      issue(1'b1, 32'h13, 3'b000, 32'h80, 0, rd, er);
      issue(1'b0, 32'h13, 3'b000, 32'h0, 0, rd, er);
      check("t2_lb", rd, 32'hFFFFFF80);
      issue(1'b0, 32'h13, 3'b100, 32'h0, 0, rd, er);
      check("t2_lbu", rd, 32'h00000080);
      issue(1'b0, 32'h10, 3'b010, 32'h0, 0, rd, er);
      check("t2_lw", rd, 32'h80ADBEEF);

      issue(1'b1, 32'h12, 3'b001, 32'h9234, 0, rd, er);
      issue(1'b0, 32'h12, 3'b001, 32'h0, 0, rd, er);
      check("t3_lh", rd, 32'hFFFF9234);
      issue(1'b0, 32'h12, 3'b101, 32'h0, 0, rd, er);
      check("t3_lhu", rd, 32'h00009234);
      issue(1'b0, 32'h10, 3'b010, 32'h0, 0, rd, er);
      check("t3_lw", rd, 32'h9234BEEF);

      issue(1'b0, 32'h10, 3'b010, 32'h0, 5, rd, er);
      check("t4_held_lw", rd, 32'h9234BEEF);

      // Store abandoned by a reset pulse while waiting.
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b1;
      bus.req_addr   = 32'h20;
      bus.req_funct3 = 3'b010;
      bus.req_wdata  = 32'h55;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("t5_resp_valid_after_rst", {31'b0, bus.resp_valid}, 32'd0);
      check("t5_req_ready_after_rst", {31'b0, bus.req_ready}, 32'd1);
      @(posedge clk); #1;
      issue(1'b0, 32'h20, 3'b010, 32'h0, 0, rd, er);
      check("t5_lw_unwritten", rd, 32'h00000000);

      issue(1'b0, 32'h10, 3'b011, 32'h0, 0, rd, er);
      check("t6_bad_load_err", {31'b0, er}, 32'd1);
      check("t6_bad_load_rd", rd, 32'd0);
      issue(1'b1, 32'h10, 3'b011, 32'hFFFFFFFF, 0, rd, er);
      check("t6_bad_store_err", {31'b0, er}, 32'd1);
      issue(1'b0, 32'h10, 3'b010, 32'h0, 0, rd, er);
      check("t6_no_write", rd, 32'h9234BEEF);

      issue(1'b0, 32'h11, 3'b010, 32'h0, 0, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
      check("t6_lw_mis_err", {31'b0, er}, 32'd1);
      check("t6_lw_mis_rd", rd, 32'd0);
`else
      check("t6_lw_mis_err", {31'b0, er}, 32'd0);
      check("t6_lw_mis_rd", rd, 32'h9234BEEF);
`endif
      issue(1'b0, 32'h13, 3'b001, 32'h0, 0, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
      check("lh_mis_err", {31'b0, er}, 32'd1);
`else
      check("lh_mis_rd", rd, 32'hFFFF9234);
`endif
      issue(1'b0, 32'h10, 3'b000, 32'h0, 0, rd, er);
      check("lb_lane0", rd, 32'hFFFFFFEF);

      issue(1'b1, 32'h1010, 3'b010, 32'h01234567, 0, rd, er);
      issue(1'b0, 32'h10, 3'b010, 32'h0, 0, rd, er);
      check("alias_lw", rd, 32'h01234567);

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
